// File: rtl/dup_range_reader.sv
// dup_range_reader: caller-side consumer of a generator's start/ready/valid/done
// protocol. It starts the callee with latched arguments and pulls its values.
// Runs of equal values are collapsed into (value, run_count) pairs. The pairs
// are offered to this module's own caller through the same generator protocol.
module dup_range_reader #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                        _clock,
  input  logic                        _reset,
  input  logic                        _start,
  input  logic signed [WIDTH-1:0]     base,
  input  logic signed [WIDTH-1:0]     limit,
  input  logic signed [WIDTH-1:0]     step,
  input  logic                        _ready,
  output logic                        _valid,
  output logic                        _done,
  output logic signed [WIDTH-1:0]     _0,
  output logic        [CNT_WIDTH-1:0] _1,
  output logic                        _callee_start,
  output logic signed [WIDTH-1:0]     _callee_base,
  output logic signed [WIDTH-1:0]     _callee_limit,
  output logic signed [WIDTH-1:0]     _callee_step,
  output logic                        _callee_ready,
  input  logic                        _callee_valid,
  input  logic                        _callee_done,
  input  logic signed [WIDTH-1:0]     _callee_0
);

  typedef enum logic [1:0] {
    IDLE_DONE = 2'd0,
    CALL      = 2'd1,
    PULL      = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_nextState;

  logic                        r_valid;
  logic                        r_done;
  logic signed [WIDTH-1:0]     r_out0;
  logic        [CNT_WIDTH-1:0] r_out1;
  logic                        r_calleeStart;
  logic signed [WIDTH-1:0]     r_calleeBase;
  logic signed [WIDTH-1:0]     r_calleeLimit;
  logic signed [WIDTH-1:0]     r_calleeStep;

  logic                        r_runActive;
  logic signed [WIDTH-1:0]     r_prev;
  logic        [CNT_WIDTH-1:0] r_cnt;

  logic                        w_outFree;
  logic                        w_calleeReady;
  logic                        w_accept;
  logic                        w_endOfStream;
  logic                        w_emitDiff;
  logic                        w_flushLoad;
  logic                        w_loadPair;
  logic                        w_cntSaturated;

  // Handshake qualifiers shared by the FSM and the datapath. The output
  // register is free when empty or being drained this cycle; the callee is only
  // pulled while it is free, so an emitted pair never overwrites an unread one.
  always_comb begin
    w_outFree      = !r_valid || _ready;
    w_calleeReady  = (r_state == PULL) && w_outFree;
    w_accept       = _callee_valid && w_calleeReady;
    w_endOfStream  = (r_state == PULL) && _callee_done && !_callee_valid;
    w_emitDiff     = w_accept && r_runActive && (_callee_0 != r_prev);
    w_flushLoad    = (r_state == FLUSH) && w_outFree;
    w_loadPair     = w_emitDiff || w_flushLoad;
    w_cntSaturated = (r_cnt == {CNT_WIDTH{1'b1}});
  end

  // Next-state logic; a new call request wins over whatever is in progress.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE_DONE: w_nextState = IDLE_DONE;
      CALL:      w_nextState = PULL;
      PULL: begin
        if (w_endOfStream) begin
          w_nextState = r_runActive ? FLUSH : IDLE_DONE;
        end
      end
      FLUSH: begin
        if (w_outFree) begin
          w_nextState = IDLE_DONE;
        end
      end
      default: w_nextState = IDLE_DONE;
    endcase
    if (_start) begin
      w_nextState = CALL;
    end
  end

  // State register; reset parks the machine in IDLE_DONE.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      r_state <= IDLE_DONE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Argument latch and one-cycle callee start pulse, coincident with CALL.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      r_calleeStart <= 1'b0;
      r_calleeBase  <= '0;
      r_calleeLimit <= '0;
      r_calleeStep  <= '0;
    end else if (_start) begin
      r_calleeStart <= 1'b1;
      r_calleeBase  <= base;
      r_calleeLimit <= limit;
      r_calleeStep  <= step;
    end else begin
      r_calleeStart <= 1'b0;
    end
  end

  // Run tracker: remembers the current value and how many times it repeated.
  // A differing value restarts the run while the finished run is emitted.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      r_runActive <= 1'b0;
      r_prev      <= '0;
      r_cnt       <= '0;
    end else if (_start) begin
      r_runActive <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!r_runActive || w_emitDiff) begin
          r_prev      <= _callee_0;
          r_cnt       <= CNT_WIDTH'(1);
          r_runActive <= 1'b1;
        end else if (!w_cntSaturated) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
      if (w_flushLoad) begin
        r_runActive <= 1'b0;
      end
    end
  end

  // Output pair register: loads a finished run, otherwise holds until drained.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      r_valid <= 1'b0;
      r_out0  <= '0;
      r_out1  <= '0;
    end else if (_start) begin
      r_valid <= 1'b0;
    end else if (w_loadPair) begin
      r_valid <= 1'b1;
      r_out0  <= r_prev;
      r_out1  <= r_cnt;
    end else if (r_valid && _ready) begin
      r_valid <= 1'b0;
    end
  end

  // Done flag: raised in IDLE_DONE once the last pair has been taken.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      r_done <= 1'b0;
    end else if (_start) begin
      r_done <= 1'b0;
    end else if ((r_state == IDLE_DONE) && w_outFree) begin
      r_done <= 1'b1;
    end
  end

  assign _valid        = r_valid;
  assign _done         = r_done;
  assign _0            = r_out0;
  assign _1            = r_out1;
  assign _callee_start = r_calleeStart;
  assign _callee_base  = r_calleeBase;
  assign _callee_limit = r_calleeLimit;
  assign _callee_step  = r_calleeStep;
  assign _callee_ready = w_calleeReady;

endmodule

// File: tb/tb_dup_range_reader.sv
// Testbench for dup_range_reader: a stub generator feeds value streams, a
// run-length model predicts the pairs, and a monitor collects the pairs the
// DUT hands out and checks that a stalled pair is held stable.
module tb_dup_range_reader;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct {
    logic signed [W-1:0] v;
    logic [CW-1:0]       c;
  } pair_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [W-1:0] base, limit, step;
  logic                ready;
  logic                valid, done;
  logic signed [W-1:0] out0;
  logic [CW-1:0]       out1;
  logic                cStart;
  logic signed [W-1:0] cBase, cLimit, cStep;
  logic                cReady;
  logic                cValid, cDone;
  logic signed [W-1:0] c0;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  logic signed [W-1:0] streamVals[$];
  logic signed [W-1:0] stubQ[$];
  pair_t               expQ[$];
  pair_t               obsQ[$];
  bit                  stubActive;
  bit                  stubBoth;
  bit                  stubGaps;
  int                  stubAccepted;
  bit                  accNext;
  bit                  startNext;
  int                  readyHoldLow;
  bit                  readyRandom;
  bit                  holdArmed;
  logic signed [W-1:0] heldV;
  logic [CW-1:0]       heldC;

  dup_range_reader #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    ._clock(clk), ._reset(rst), ._start(start),
    .base(base), .limit(limit), .step(step),
    ._ready(ready), ._valid(valid), ._done(done), ._0(out0), ._1(out1),
    ._callee_start(cStart), ._callee_base(cBase), ._callee_limit(cLimit),
    ._callee_step(cStep), ._callee_ready(cReady), ._callee_valid(cValid),
    ._callee_done(cDone), ._callee_0(c0)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: group consecutive equal values, count saturating at MAXC.
  task automatic buildExpected();
    int i, j, n;
    pair_t p;
    expQ.delete();
    i = 0;
    while (i < streamVals.size()) begin
      j = i;
      while (j < streamVals.size() && streamVals[j] == streamVals[i]) j++;
      n = j - i;
      p.v = streamVals[i];
      p.c = CW'((n > MAXC) ? MAXC : n);
      expQ.push_back(p);
      i = j;
    end
  endtask

  // Stub callee: loads the stream when started, offers values with optional
  // gaps, and signals done (optionally together with the last value).
  initial begin
    cValid = 1'b0; cDone = 1'b0; c0 = '0; stubActive = 1'b0;
    stubAccepted = 0;
    forever begin
      @(posedge clk);
      #1;
      if (startNext) begin
        stubQ = streamVals;
        stubActive = 1'b1;
      end else if (accNext) begin
        void'(stubQ.pop_front());
        stubAccepted++;
      end
      cValid = stubActive && (stubQ.size() > 0) && !(stubGaps && ($urandom_range(0, 3) == 0));
      c0 = (stubQ.size() > 0) ? stubQ[0] : '0;
      cDone = stubActive && ((stubQ.size() == 0) || (stubBoth && stubQ.size() == 1 && cValid));
    end
  end

  // Ready driver for the DUT's own output port.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (readyHoldLow > 0) begin
        ready = 1'b0;
        readyHoldLow--;
      end else begin
        ready = readyRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
    end
  end

  // Monitor: records handed-out pairs and checks stall behaviour.
  initial begin
    holdArmed = 1'b0;
    forever begin
      @(negedge clk);
      accNext = cValid && cReady;
      startNext = cStart;
      if (holdArmed) begin
        checkOutput("hold_valid", 64'(valid), 64'd1);
        checkOutput("hold_value", 64'(out0), 64'(heldV));
        checkOutput("hold_count", 64'(out1), 64'(heldC));
      end
      if (rst && valid && !ready) checkOutput("stall_callee_ready", 64'(cReady), 64'd0);
      if (rst && valid) checkOutput("count_nonzero", 64'(out1 != 0), 64'd1);
      if (rst && valid && ready) obsQ.push_back('{v: out0, c: out1});
      holdArmed = rst && valid && !ready;
      heldV = out0;
      heldC = out1;
    end
  end

  task automatic applyStimulus(input logic signed [W-1:0] b, input logic signed [W-1:0] l,
                               input logic signed [W-1:0] s);
    buildExpected();
    @(posedge clk);
    #2;
    stubAccepted = 0;
    base = b; limit = l; step = s;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    @(negedge clk);
    checkOutput("callee_start_pulse", 64'(cStart), 64'd1);
    checkOutput("callee_base", 64'(cBase), 64'(b));
    checkOutput("callee_limit", 64'(cLimit), 64'(l));
    checkOutput("callee_step", 64'(cStep), 64'(s));
    checkOutput("done_cleared", 64'(done), 64'd0);
  endtask

  task automatic waitForDone(input string tag, input int expCycles);
    int cyc;
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) checkOutput({tag, "_start_one_cycle"}, 64'(cStart), 64'd0);
      if (done && !valid) seen = 1'b1;
    end
    checkOutput({tag, "_finished"}, 64'(seen), 64'd1);
    if (expCycles >= 0) checkOutput({tag, "_latency"}, 64'(cyc), 64'(expCycles));
    checkOutput({tag, "_pair_count"}, 64'(obsQ.size()), 64'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < obsQ.size(); k++) begin
      checkOutput($sformatf("%s_pair%0d_value", tag, k), 64'(obsQ[k].v), 64'(expQ[k].v));
      checkOutput($sformatf("%s_pair%0d_count", tag, k), 64'(obsQ[k].c), 64'(expQ[k].c));
    end
    obsQ.delete();
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b0; start = 1'b0; base = 7; limit = 8; step = 9;
    stubBoth = 1'b0; stubGaps = 1'b0; readyRandom = 1'b0; readyHoldLow = 0;
    streamVals.delete();

    $display("[TB] reset phase");
    repeat (2) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_out0", 64'(out0), 64'd0);
    checkOutput("rst_out1", 64'(out1), 64'd0);
    checkOutput("rst_over_start", 64'(cStart), 64'd0);
    checkOutput("rst_callee_base", 64'(cBase), 64'd0);
    checkOutput("rst_callee_ready", 64'(cReady), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release_done", 64'(done), 64'd1);
    checkOutput("release_callee_ready", 64'(cReady), 64'd0);
    checkOutput("release_valid", 64'(valid), 64'd0);

    $display("[TB] ten zeros");
    streamVals = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(0, 10, 2);
    waitForDone("zeros", 14);

    $display("[TB] mixed runs, ready high");
    streamVals = '{5, 5, 7, 7, 7, -3};
    applyStimulus(1, 2, 3);
    waitForDone("mixed", 10);

    $display("[TB] mixed runs, output stalled");
    readyHoldLow = 100000;
    applyStimulus(-4, 40, -1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    checkOutput("stall_pair_seen", 64'(seen), 64'd1);
    repeat (6) @(negedge clk);
    checkOutput("stall_accepted", 64'(stubAccepted), 64'd3);
    readyHoldLow = 0;
    waitForDone("stalled", -1);

    $display("[TB] empty stream");
    streamVals.delete();
    applyStimulus(3, 3, 1);
    waitForDone("empty", 3);

    $display("[TB] saturating run");
    streamVals.delete();
    for (int i = 0; i < 20; i++) streamVals.push_back(4);
    streamVals.push_back(9);
    applyStimulus(0, 21, 1);
    waitForDone("saturate", -1);

    $display("[TB] reset mid-stream");
    readyHoldLow = 100000;
    streamVals = '{5, 5, 7, 9, 9};
    applyStimulus(0, 5, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (stubAccepted == 3 && valid) seen = 1'b1;
    end
    checkOutput("midrst_pending", 64'(seen), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(valid), 64'd0);
    checkOutput("midrst_out1", 64'(out1), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    readyHoldLow = 0;
    obsQ.delete();
    stubGaps = 1'b1;
    streamVals = '{1, 1};
    applyStimulus(1, 2, 1);
    waitForDone("after_rst", -1);

    $display("[TB] randomized streams");
    readyRandom = 1'b1;
    for (int it = 0; it < 12; it++) begin
      streamVals.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++) streamVals.push_back(W'(int'($urandom_range(0, 4)) - 2));
      stubBoth = ($urandom_range(0, 1) == 1);
      applyStimulus($urandom, $urandom, $urandom);
      waitForDone($sformatf("rand%0d", it), -1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
